// File: rtl/mii_rx_nibble_assembler.sv
// mii_rx_nibble_assembler: strips MII preamble/SFD and assembles low-nibble-first bytes into a byte stream.
// Optional statistics counters are enabled by defining MII_RX_STATS_EN.
module mii_rx_nibble_assembler #(
    parameter int MAX_LEN   = 1522,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           mii_rxd,
    input  logic                 mii_rx_dv,
    input  logic                 mii_rx_er,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser
`ifdef MII_RX_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] stat_frames_good,
    output logic [CNT_WIDTH-1:0] stat_frames_bad,
    output logic [CNT_WIDTH-1:0] stat_preamble_err
`endif
);
    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    state_t               state, nxt_state;
    logic                 phase, nxt_phase;
    logic [3:0]           low, nxt_low;
    logic [7:0]           hold, nxt_hold;
    logic                 hold_vld, nxt_hold_vld;
    logic                 err_seen, nxt_err;
    logic [CNT_WIDTH-1:0] cnt, nxt_cnt, cnt_inc;
    logic [7:0]           nxt_tdata;
    logic                 nxt_tvalid, nxt_tlast, nxt_tuser;
    logic                 silent_drop, pre_err;

    assign cnt_inc = cnt + 1'b1;

    // Next-state, assembly and output decode; a completed byte waits in hold until the
    // next byte or the end of frame tells us whether it is the last one.
    always_comb begin
        nxt_state    = state;
        nxt_phase    = phase;
        nxt_low      = low;
        nxt_hold     = hold;
        nxt_hold_vld = hold_vld;
        nxt_err      = err_seen;
        nxt_cnt      = cnt;
        nxt_tdata    = 8'h00;
        nxt_tvalid   = 1'b0;
        nxt_tlast    = 1'b0;
        nxt_tuser    = 1'b0;
        silent_drop  = 1'b0;
        pre_err      = 1'b0;
        case (state)
            IDLE, PREAMBLE: begin
                if (!mii_rx_dv) begin
                    nxt_state = IDLE;
                end else if (mii_rxd == 4'h5) begin
                    nxt_state = PREAMBLE;
                end else if (mii_rxd == 4'hD) begin
                    nxt_state    = DATA;
                    nxt_phase    = 1'b0;
                    nxt_err      = 1'b0;
                    nxt_cnt      = '0;
                    nxt_hold_vld = 1'b0;
                end else begin
                    nxt_state = DROP;
                    pre_err   = 1'b1;
                end
            end
            DATA: begin
                if (mii_rx_dv) begin
                    nxt_err = err_seen | mii_rx_er;
                    if (!phase) begin
                        nxt_low   = mii_rxd;
                        nxt_phase = 1'b1;
                    end else begin
                        nxt_phase    = 1'b0;
                        nxt_cnt      = cnt_inc;
                        nxt_tvalid   = hold_vld;
                        nxt_tdata    = hold_vld ? hold : 8'h00;
                        nxt_hold     = {mii_rxd, low};
                        nxt_hold_vld = 1'b1;
                        nxt_state    = (cnt_inc == CNT_WIDTH'(MAX_LEN)) ? DROP : DATA;
                    end
                end else begin
                    nxt_tvalid   = hold_vld;
                    nxt_tlast    = hold_vld;
                    nxt_tuser    = hold_vld & (err_seen | phase);
                    nxt_tdata    = hold_vld ? hold : 8'h00;
                    silent_drop  = ~hold_vld;
                    nxt_hold_vld = 1'b0;
                    nxt_state    = IDLE;
                end
            end
            default: begin
                nxt_tvalid   = hold_vld;
                nxt_tlast    = hold_vld;
                nxt_tuser    = hold_vld;
                nxt_tdata    = hold_vld ? hold : 8'h00;
                nxt_hold_vld = 1'b0;
                nxt_state    = mii_rx_dv ? DROP : IDLE;
            end
        endcase
    end

    // State, assembly registers and registered stream outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            phase         <= 1'b0;
            low           <= 4'h0;
            hold          <= 8'h00;
            hold_vld      <= 1'b0;
            err_seen      <= 1'b0;
            cnt           <= '0;
            m_axis_tdata  <= 8'h00;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
        end else begin
            state         <= nxt_state;
            phase         <= nxt_phase;
            low           <= nxt_low;
            hold          <= nxt_hold;
            hold_vld      <= nxt_hold_vld;
            err_seen      <= nxt_err;
            cnt           <= nxt_cnt;
            m_axis_tdata  <= nxt_tdata;
            m_axis_tvalid <= nxt_tvalid;
            m_axis_tlast  <= nxt_tlast;
            m_axis_tuser  <= nxt_tuser;
        end
    end

`ifdef MII_RX_STATS_EN
    // Saturating frame and preamble-error statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_frames_good  <= '0;
            stat_frames_bad   <= '0;
            stat_preamble_err <= '0;
        end else begin
            if (nxt_tvalid && nxt_tlast && !nxt_tuser && !(&stat_frames_good))
                stat_frames_good <= stat_frames_good + 1'b1;
            if (((nxt_tvalid && nxt_tlast && nxt_tuser) || silent_drop) && !(&stat_frames_bad))
                stat_frames_bad <= stat_frames_bad + 1'b1;
            if (pre_err && !(&stat_preamble_err))
                stat_preamble_err <= stat_preamble_err + 1'b1;
        end
    end
`endif
endmodule
